// File: rtl/multicycle_sequencer.sv
// Main control sequencer for the multicycle MIPS datapath.
// Walks each instruction through IF/ID/EX/MEM/WB, raising the PC, IR,
// ALU-latch, memory and register-file strobes, with a memory-wait
// watchdog, halt handling, illegal-instruction trap and retire counter.
module multicycle_sequencer #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_mem_ready,
    input  logic             i_isLoad,
    input  logic             i_dMemWe,
    input  logic             i_regWe,
    input  logic [3:0]       i_BRop,
    input  logic [4:0]       i_sALU,
    input  logic             i_halt,
    output logic [2:0]       o_state,
    output logic             o_memRe,
    output logic             o_memWe,
    output logic             o_irWe,
    output logic             o_pcWe,
    output logic             o_pcBrWe,
    output logic             o_aluLatch,
    output logic             o_regWe,
    output logic             o_illegal,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [3:0] BR_NONE    = 4'd13;
    localparam logic [4:0] ALU_NONE   = 5'd13;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       wait_cnt;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;
    logic             timeout_q;

    logic is_branch;
    logic is_link;
    logic is_illegal;
    logic waiting;
    logic wait_trip;
    logic retire;
    logic set_illegal;
    logic set_timeout;

    assign is_branch  = (i_BRop != BR_NONE);
    assign is_link    = (i_BRop == 4'd2) || (i_BRop == 4'd3) ||
                        (i_BRop == 4'd4) || (i_BRop == 4'd7);
    assign is_illegal = (i_BRop == BR_NONE) && (i_sALU == ALU_NONE) &&
                        !i_isLoad && !i_dMemWe;

    // A memory wait is an IF or MEM cycle without ready; the trip fires on
    // the wait cycle that brings the count up to MAX_WAIT.
    assign waiting   = ((state == S_IF) || (state == S_MEM)) && !i_mem_ready;
    assign wait_trip = waiting && ((wait_cnt + 8'd1) == WAIT_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IF;
        end else begin
            state <= state_nxt;
        end
    end

    // Wait counter, retire counter and sticky fault flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= 8'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (waiting && (state_nxt == state)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'd0;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Next-state decode; every path that completes an instruction funnels
    // through the retire flag so the halt request is honoured in one place.
    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IF: begin
                if (i_mem_ready) begin
                    state_nxt = S_ID;
                end else if (wait_trip) begin
                    state_nxt   = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_ID: begin
                if (is_illegal) begin
                    state_nxt   = S_HALT;
                    set_illegal = 1'b1;
                end else begin
                    state_nxt = S_EX;
                end
            end
            S_EX: begin
                if (is_branch) begin
                    if (is_link) begin
                        state_nxt = S_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (i_isLoad || i_dMemWe) begin
                    state_nxt = S_MEM;
                end else if (i_regWe) begin
                    state_nxt = S_WB;
                end else begin
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                if (i_mem_ready) begin
                    if (i_isLoad) begin
                        state_nxt = S_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (wait_trip) begin
                    state_nxt   = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_HALT: begin
                if (!illegal_q && !timeout_q && !i_halt) begin
                    state_nxt = S_IF;
                end
            end
            default: begin
                state_nxt = S_IF;
            end
        endcase
        if (retire) begin
            state_nxt = i_halt ? S_HALT : S_IF;
        end
    end

    // Strobe decode from the current state; reset masks everything.
    always_comb begin
        o_memRe    = 1'b0;
        o_memWe    = 1'b0;
        o_irWe     = 1'b0;
        o_pcWe     = 1'b0;
        o_pcBrWe   = 1'b0;
        o_aluLatch = 1'b0;
        o_regWe    = 1'b0;
        if (!rst) begin
            case (state)
                S_IF: begin
                    o_memRe = 1'b1;
                    o_irWe  = i_mem_ready;
                    o_pcWe  = i_mem_ready;
                end
                S_EX: begin
                    o_aluLatch = 1'b1;
                    o_pcBrWe   = is_branch;
                end
                S_MEM: begin
                    o_memRe = i_isLoad;
                    o_memWe = i_dMemWe;
                end
                S_WB: begin
                    o_regWe = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_state   = rst ? 3'd0 : state;
    assign o_illegal = illegal_q;
    assign o_timeout = timeout_q;
    assign o_retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomised bench for multicycle_sequencer: a driver issues instructions
// and pushes the per-instruction expectations; a monitor accumulates the
// strobes of each instruction and compares when the instruction ends.
module tb_multicycle_sequencer;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_mem_ready = 1'b0;
    logic             i_isLoad = 1'b0;
    logic             i_dMemWe = 1'b0;
    logic             i_regWe = 1'b0;
    logic [3:0]       i_BRop = 4'd13;
    logic [4:0]       i_sALU = 5'd0;
    logic             i_halt = 1'b0;
    logic [2:0]       o_state;
    logic             o_memRe, o_memWe, o_irWe, o_pcWe, o_pcBrWe;
    logic             o_aluLatch, o_regWe, o_illegal, o_timeout;
    logic [CNT_W-1:0] o_retired;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .i_mem_ready(i_mem_ready), .i_isLoad(i_isLoad),
        .i_dMemWe(i_dMemWe), .i_regWe(i_regWe), .i_BRop(i_BRop), .i_sALU(i_sALU),
        .i_halt(i_halt), .o_state(o_state), .o_memRe(o_memRe), .o_memWe(o_memWe),
        .o_irWe(o_irWe), .o_pcWe(o_pcWe), .o_pcBrWe(o_pcBrWe),
        .o_aluLatch(o_aluLatch), .o_regWe(o_regWe), .o_illegal(o_illegal),
        .o_timeout(o_timeout), .o_retired(o_retired)
    );

    // Expected summary of one instruction, from its first IF cycle to the
    // cycle before it lands in IF or HALT.
    typedef struct {
        int cycles; int ir; int pc; int br; int alu; int rw; int mwe; int mre;
        int end_state; int ill; int tmo; int ret;
    } exp_t;

    exp_t sb[$];
    int   exit_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_ret = 0;
    int   link_ops[4]   = '{2, 3, 4, 7};
    int   plain_ops[11] = '{0, 1, 5, 6, 8, 9, 10, 11, 12, 14, 15};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_halt = 1'b0;
        i_mem_ready = 1'($urandom_range(0, 1));
        tick();
        tick();
        rst = 1'b0;
        model_ret = 0;
    endtask

    // kind: 0 ALU with write, 1 ALU without write, 2 load, 3 store,
    //       4 link branch, 5 plain branch, 6 illegal.
    task automatic do_instr(input int kind, input int wif, input int wmem,
                            input bit hlt, input int hextra, input int abort_at);
        exp_t e;
        bit   rq[$];
        int   br;
        int   alu;
        bit   ld, st, rw, term, aborted;
        int   n;
        ld = 1'b0; st = 1'b0; rw = 1'($urandom_range(0, 1)); br = 13;
        alu = $urandom_range(0, 31);
        case (kind)
            0: begin rw = 1'b1; if (alu == 13) alu = 0; end
            1: begin rw = 1'b0; if (alu == 13) alu = 1; end
            2: begin ld = 1'b1; rw = 1'b1; end
            3: st = 1'b1;
            4: br = link_ops[$urandom_range(0, 3)];
            5: br = plain_ops[$urandom_range(0, 10)];
            default: alu = 13;
        endcase

        e = '{default: 0};
        if (wif >= MAX_WAIT) begin
            for (int i = 0; i < MAX_WAIT; i++) rq.push_back(1'b0);
            e.mre = MAX_WAIT;
            e.tmo = 1;
        end else begin
            for (int i = 0; i < wif; i++) rq.push_back(1'b0);
            rq.push_back(1'b1);
            e.mre = wif + 1; e.ir = 1; e.pc = 1;
            rq.push_back(1'($urandom_range(0, 1)));
            if (kind == 6) begin
                e.ill = 1;
            end else begin
                rq.push_back(1'($urandom_range(0, 1)));
                e.alu = 1;
                if (kind == 4 || kind == 5) begin
                    e.br = 1;
                    if (kind == 4) begin
                        rq.push_back(1'($urandom_range(0, 1)));
                        e.rw = 1;
                    end
                end else if (kind == 2 || kind == 3) begin
                    n = (wmem >= MAX_WAIT) ? MAX_WAIT : wmem + 1;
                    for (int i = 0; i < n; i++) rq.push_back(i == wmem);
                    if (kind == 2) e.mre += n; else e.mwe = n;
                    if (wmem >= MAX_WAIT) begin
                        e.tmo = 1;
                    end else if (kind == 2) begin
                        rq.push_back(1'($urandom_range(0, 1)));
                        e.rw = 1;
                    end
                end else if (kind == 0) begin
                    rq.push_back(1'($urandom_range(0, 1)));
                    e.rw = 1;
                end
            end
        end
        e.cycles    = rq.size();
        term        = (e.ill != 0) || (e.tmo != 0);
        e.end_state = (term || hlt) ? 5 : 0;
        e.ret       = term ? model_ret : (model_ret + 1) % (1 << CNT_W);
        aborted     = (abort_at >= 0) && (abort_at < e.cycles);
        n           = aborted ? abort_at : e.cycles;
        if (!aborted) sb.push_back(e);
        if (!aborted && !term && hlt) exit_q.push_back(hextra + 1);

        i_isLoad = ld; i_dMemWe = st; i_regWe = rw;
        i_BRop = 4'(br); i_sALU = 5'(alu);
        for (int k = 0; k < n; k++) begin
            i_mem_ready = rq[k];
            i_halt = (k == e.cycles - 1) ? hlt : 1'($urandom_range(0, 1));
            tick();
        end
        if (aborted) begin
            do_reset();
        end else if (term) begin
            for (int k = 0; k < 3; k++) begin
                i_halt = 1'($urandom_range(0, 1));
                i_mem_ready = 1'($urandom_range(0, 1));
                tick();
            end
            do_reset();
        end else begin
            model_ret = e.ret;
            if (hlt) begin
                for (int k = 0; k < hextra; k++) begin
                    i_halt = 1'b1;
                    i_mem_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                i_halt = 1'b0;
                tick();
            end
        end
    endtask

    // Monitor: per-cycle invariants, reset checks and instruction-end compare.
    int prev_state = 5;
    int prev_rst   = 1;
    int halt_run   = 0;
    int a_cyc, a_ir, a_pc, a_br, a_alu, a_rw, a_mwe, a_mre;
    initial begin
        exp_t e;
        int   cur;
        bit   end_ev;
        a_cyc = 0; a_ir = 0; a_pc = 0; a_br = 0; a_alu = 0; a_rw = 0; a_mwe = 0; a_mre = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_state", int'(o_state), 0);
                chk("rst_strobes", int'({o_memRe, o_memWe, o_irWe, o_pcWe,
                                          o_pcBrWe, o_aluLatch, o_regWe}), 0);
                if (prev_rst != 0) begin
                    chk("rst_retired", int'(o_retired), 0);
                    chk("rst_flags", int'({o_illegal, o_timeout}), 0);
                end
                a_cyc = 0; a_ir = 0; a_pc = 0; a_br = 0; a_alu = 0; a_rw = 0; a_mwe = 0; a_mre = 0;
                prev_state = 5;
                halt_run = 0;
                prev_rst = 1;
            end else begin
                prev_rst = 0;
                cur = int'(o_state);
                chk("pc_exclusive", int'(o_pcWe & o_pcBrWe), 0);
                end_ev = (cur == 0 || cur == 5) && prev_state != 5 &&
                         !(prev_state == 0 && cur == 0);
                if (end_ev) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("cycles", a_cyc, e.cycles);
                        chk("irWe_cnt", a_ir, e.ir);
                        chk("pcWe_cnt", a_pc, e.pc);
                        chk("pcBrWe_cnt", a_br, e.br);
                        chk("aluLatch_cnt", a_alu, e.alu);
                        chk("regWe_cnt", a_rw, e.rw);
                        chk("memWe_cnt", a_mwe, e.mwe);
                        chk("memRe_cnt", a_mre, e.mre);
                        chk("end_state", cur, e.end_state);
                        chk("illegal", int'(o_illegal), e.ill);
                        chk("timeout", int'(o_timeout), e.tmo);
                        chk("retired", int'(o_retired), e.ret);
                    end
                    a_cyc = 0; a_ir = 0; a_pc = 0; a_br = 0; a_alu = 0; a_rw = 0; a_mwe = 0; a_mre = 0;
                end
                if (prev_state == 5 && cur == 0 && halt_run > 0) begin
                    if (exit_q.size() == 0) chk("halt_exit_unexpected", halt_run, 0);
                    else chk("halt_len", halt_run, exit_q.pop_front());
                end
                halt_run = (cur == 5) ? halt_run + 1 : 0;
                if (cur != 5) begin
                    a_cyc++;
                    a_ir  += int'(o_irWe);
                    a_pc  += int'(o_pcWe);
                    a_br  += int'(o_pcBrWe);
                    a_alu += int'(o_aluLatch);
                    a_rw  += int'(o_regWe);
                    a_mwe += int'(o_memWe);
                    a_mre += int'(o_memRe);
                end
                prev_state = cur;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1, "simulation time limit");
    end

    // Driver: directed cases first, then a randomised instruction stream.
    initial begin
        int kind, wif, wmem, ab;
        bit hlt;
        do_reset();
        do_instr(0, 0, 0, 1'b0, 0, -1);    // ALU op, 4 cycles
        do_instr(2, 0, 3, 1'b0, 0, -1);    // lw with 3 MEM waits, 8 cycles
        do_instr(3, 0, 0, 1'b0, 0, -1);    // sw
        do_instr(4, 0, 0, 1'b0, 0, -1);    // link branch
        do_instr(5, 0, 0, 1'b0, 0, -1);    // plain branch
        do_instr(6, 0, 0, 1'b0, 0, -1);    // illegal, then reset
        do_instr(0, 15, 0, 1'b0, 0, -1);   // fetch watchdog trip
        do_instr(0, 14, 0, 1'b0, 0, -1);   // ready on the last allowed wait
        do_instr(2, 1, 15, 1'b0, 0, -1);   // MEM watchdog trip
        do_instr(3, 0, 14, 1'b0, 0, -1);   // MEM ready on the last allowed wait
        do_instr(0, 0, 0, 1'b1, 0, -1);    // halt at retire, leave next cycle
        do_instr(1, 2, 0, 1'b1, 2, -1);    // halt held a few cycles
        do_instr(3, 0, 2, 1'b0, 0, 4);     // reset during MEM of a store
        for (int i = 0; i < 17; i++) do_instr(i % 2, 0, 0, 1'b0, 0, -1);  // counter wrap
        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 6);
            if (kind == 6 && $urandom_range(0, 2) != 0) kind = 0;
            wif  = ($urandom_range(0, 14) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 3);
            wmem = ($urandom_range(0, 14) == 0) ? $urandom_range(14, 15) : $urandom_range(0, 3);
            hlt  = ($urandom_range(0, 3) == 0);
            ab   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : -1;
            do_instr(kind, wif, wmem, hlt, $urandom_range(0, 2), ab);
        end
        i_mem_ready = 1'b0;
        i_halt = 1'b0;
        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        chk("exit_q_drained", exit_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Main state machine for the multicycle MIPS datapath.
- Steps each instruction through IF, ID, EX, MEM and WB, driving the PC, IR, ALU-latch, memory and register-file strobes.
- Decode inputs come combinationally from the control unit, which decodes the IR. They are stable from ID until the instruction retires.
- Also handles memory wait states, a wait watchdog, halt requests, illegal-instruction trapping and a retired-instruction counter.

Parameters:
CNT_W, 32, width of the retired-instruction counter.
MAX_WAIT, 15, number of consecutive cycles without i_mem_ready after which the watchdog trips (1..255).

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
i_mem_ready  in  1  memory accepts or completes the current access this cycle.
i_isLoad  in  1  decoded instruction is lw or lb.
i_dMemWe  in  1  decoded instruction is sw or sb.
i_regWe  in  1  decoded instruction writes the register file.
i_BRop  in  4  branch/jump code; 13 means not a branch.
i_sALU  in  5  ALU op code; 13 means none/illegal.
i_halt  in  1  request to stop at the next instruction boundary.
o_state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
o_memRe  out  1  memory read strobe (fetch or load).
o_memWe  out  1  data memory write strobe.
o_irWe  out  1  IR load.
o_pcWe  out  1  PC <= PC+4.
o_pcBrWe  out  1  PC <= branch/jump target; the datapath comparator qualifies it.
o_aluLatch  out  1  ALU-out register load.
o_regWe  out  1  register-file write.
o_illegal  out  1  sticky illegal-instruction flag.
o_timeout  out  1  sticky watchdog flag.
o_retired  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (rst=1 at an edge):
  - state becomes IF; wait counter, o_retired, o_illegal and o_timeout become 0.
  - While rst=1, all strobes are forced 0 and o_state reads 0.
  - Reset mid-instruction abandons it with no write strobe.
- Strobes are Moore-style, decoded from the state register plus the decode inputs. At most one of o_pcWe and o_pcBrWe is high in any cycle.
- Classes:
  - Link = BRop in {2, 3, 4, 7}.
  - Branch = BRop != 13.
  - Illegal = BRop==13 and sALU==13 and !isLoad and !dMemWe.
- Retire event: the transition into IF or HALT that completes an instruction. At a retire event, o_retired increments, wrapping mod 2^CNT_W. The next state is HALT if i_halt=1 that cycle, else IF.
- IF:
  - o_memRe=1.
  - If i_mem_ready=1: o_irWe=1 and o_pcWe=1 in the same cycle, then go to ID.
  - Otherwise stay in IF.
- ID:
  - No strobes (register read only).
  - If Illegal: o_illegal is set, go to HALT, no retire.
  - Otherwise go to EX.
- EX: o_aluLatch=1.
  - Branch: o_pcBrWe=1. If Link, go to WB; else retire.
  - Else if isLoad or dMemWe: go to MEM.
  - Else if regWe: go to WB.
  - Else: retire.
- MEM:
  - o_memRe=isLoad and o_memWe=dMemWe, both held until i_mem_ready=1.
  - On ready: a load goes to WB; a store retires.
- WB: o_regWe=1 for exactly one cycle, then retire.
- Latency without waits: ALU op 4 cycles; load 5; store 4; plain branch 3; link branch 4.
- Watchdog:
  - The wait counter increments each cycle in IF or MEM with i_mem_ready=0, and clears on state change or when ready=1.
  - When the count reaches MAX_WAIT, the next state is HALT and o_timeout is set. No retire occurs and no IR/PC/reg write happens.
  - If i_mem_ready=1 in the same cycle the count would reach MAX_WAIT, the access completes normally.
- HALT:
  - All strobes are 0.
  - If o_illegal or o_timeout is set, only rst exits.
  - Otherwise, go to IF the cycle after i_halt=0.
- i_halt asserted mid-instruction has no effect until the retire event.

Test Plan:
1. ALU op (sALU=0, regWe=1, BRop=13), mem_ready always 1 → states 0,1,2,4,0. irWe and pcWe in cycle 0, aluLatch in cycle 2, regWe in cycle 3; o_retired=1 after 4 cycles.
2. lw (isLoad=1, regWe=1) with mem_ready low for 3 MEM cycles → memRe high for 4 MEM cycles, then WB with regWe=1; total 8 cycles; o_memWe never 1.
3. sw (dMemWe=1), then jal (BRop=2), then beq (BRop=9) → sw: memWe in MEM, 4 cycles, no regWe. jal: pcBrWe in EX then regWe in WB, 4 cycles. beq: pcBrWe in EX, retires after 3 cycles. o_retired=3.
4. Illegal decode (BRop=13, sALU=13, no load/store) → HALT after ID, o_illegal=1, o_retired unchanged, stuck in HALT until rst; rst clears the flag and state=IF.
5. MAX_WAIT=15, mem_ready held 0 in IF → HALT after 15 wait cycles with o_timeout=1 and no irWe. Repeat with ready=1 in wait cycle 15 → normal fetch, no timeout.
6. i_halt=1 during EX of an ALU op → WB completes, state=HALT, o_retired increments. Drop i_halt → IF next cycle. rst asserted in MEM of an sw → memWe 0 during reset and state=IF.
